// File: rtl/pp_periph_bridge_pkg.sv
// Shared definitions for the core-to-peripheral bridge: FSM states, the
// default window base and the byte-enable patterns the bridge accepts.
package pp_periph_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_RESP    = 2'd3
  } state_t;

  localparam logic [31:0] PP_BASE_ADDR = 32'h1000_0000;
  localparam int          PP_WIN_BITS  = 8;

  // Byte-enable patterns the peripheral bus can carry.
  localparam logic [3:0] BE_B0 = 4'b0001;
  localparam logic [3:0] BE_B1 = 4'b0010;
  localparam logic [3:0] BE_B2 = 4'b0100;
  localparam logic [3:0] BE_B3 = 4'b1000;
  localparam logic [3:0] BE_H0 = 4'b0011;
  localparam logic [3:0] BE_H1 = 4'b1100;
  localparam logic [3:0] BE_W  = 4'b1111;

  // Index of the lowest enabled byte lane.
  function automatic logic [1:0] be_offset(input logic [3:0] be);
    if (be[0])      return 2'd0;
    else if (be[1]) return 2'd1;
    else if (be[2]) return 2'd2;
    else            return 2'd3;
  endfunction

  // True for a byte-enable shape the bridge can translate.
  function automatic logic be_pattern_ok(input logic [3:0] be);
    case (be)
      BE_B0, BE_B1, BE_B2, BE_B3, BE_H0, BE_H1, BE_W: return 1'b1;
      default:                                        return 1'b0;
    endcase
  endfunction

  // Expands byte enables into a 32-bit data mask.
  function automatic logic [31:0] byte_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

endpackage

// File: rtl/pp_lane_align.sv
// Combinational lane logic: request legality, lane offset, and the
// write-down / read-up shifts between core lanes and peripheral bit 0.
module pp_lane_align
  import pp_periph_bridge_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = PP_BASE_ADDR,
  parameter int          WIN_BITS  = PP_WIN_BITS
) (
  input  logic [31:WIN_BITS] req_page,
  input  logic [1:0]         req_lo,
  input  logic [3:0]         req_be,
  input  logic [31:0]        req_wdata,
  input  logic [1:0]         cap_offset,
  input  logic [31:0]        cap_rdata,
  output logic               req_legal,
  output logic [1:0]         req_offset,
  output logic [31:0]        wr_down,
  output logic [31:0]        rd_up
);

  logic in_window;

  // Legality: inside the window, a supported shape, and aligned to its lowest lane.
  always_comb begin
    req_offset = be_offset(req_be);
    in_window  = (req_page == BASE_ADDR[31:WIN_BITS]);
    req_legal  = in_window && be_pattern_ok(req_be) && (req_lo == req_offset);
  end

  // Lane shifts: selected store lanes drop to bit 0; load data rises to its lane.
  always_comb begin
    wr_down = (req_wdata & byte_mask(req_be)) >> {req_offset, 3'b000};
    rd_up   = cap_rdata << {cap_offset, 3'b000};
  end

endmodule

// File: rtl/pp_periph_bridge.sv
// Bridge from the core data-memory port to the 8-bit-address peripheral bus.
// One transaction at a time; every legal request produces exactly one
// peripheral strobe, illegal ones produce none and answer with an error.
//
// Handshake: the core raises dmem_req and holds it (with its fields stable)
// until a cycle in which dmem_gnt is high; that cycle is the acceptance.
// dmem_rvalid is a single-cycle strobe with dmem_err/dmem_rdata valid
// alongside it; there is no back-pressure on the response.
module pp_periph_bridge
  import pp_periph_bridge_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = PP_BASE_ADDR,
  parameter int          WIN_BITS  = PP_WIN_BITS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dmem_req,
  input  logic        dmem_we,
  input  logic [31:0] dmem_addr,
  input  logic [3:0]  dmem_be,
  input  logic [31:0] dmem_wdata,
  output logic        dmem_gnt,
  output logic        dmem_rvalid,
  output logic        dmem_err,
  output logic [31:0] dmem_rdata,
  output logic [7:0]  p_addr,
  output logic        p_wr,
  output logic        p_rd,
  output logic [31:0] p_wdata,
  input  logic [31:0] p_rdata,
  output state_t      dbg_state
);

  state_t      state_q, state_d;
  logic        we_q;
  logic [1:0]  off_q;
  logic        err_q;
  logic [31:0] rdata_q;
  logic [7:0]  p_addr_q;
  logic [31:0] p_wdata_q;

  logic        accept;
  logic        req_legal;
  logic [1:0]  req_offset;
  logic [31:0] wr_down;
  logic [31:0] rd_up;

  pp_lane_align #(
    .BASE_ADDR (BASE_ADDR),
    .WIN_BITS  (WIN_BITS)
  ) u_lane_align (
    .req_page   (dmem_addr[31:WIN_BITS]),
    .req_lo     (dmem_addr[1:0]),
    .req_be     (dmem_be),
    .req_wdata  (dmem_wdata),
    .cap_offset (off_q),
    .cap_rdata  (p_rdata),
    .req_legal  (req_legal),
    .req_offset (req_offset),
    .wr_down    (wr_down),
    .rd_up      (rd_up)
  );

  // Next state and state-decoded outputs.
  always_comb begin
    state_d     = state_q;
    dmem_gnt    = 1'b0;
    dmem_rvalid = 1'b0;
    p_wr        = 1'b0;
    p_rd        = 1'b0;
    accept      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        dmem_gnt = 1'b1;
        accept   = dmem_req;
        if (dmem_req) state_d = req_legal ? ST_ACCESS : ST_RESP;
      end
      ST_ACCESS: begin
        p_wr    = we_q;
        p_rd    = ~we_q;
        state_d = we_q ? ST_RESP : ST_CAPTURE;
      end
      ST_CAPTURE: state_d = ST_RESP;
      ST_RESP: begin
        dmem_rvalid = 1'b1;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register; reset aborts any transaction in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Request latch, peripheral drive registers and response registers.
  // Peripheral address/data only change on a legal acceptance so they hold
  // their last value between strobes; response fields clear after RESP.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we_q      <= 1'b0;
      off_q     <= 2'd0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
      p_addr_q  <= '0;
      p_wdata_q <= '0;
    end else begin
      if (accept) begin
        we_q    <= dmem_we;
        off_q   <= req_offset;
        err_q   <= ~req_legal;
        rdata_q <= '0;
        if (req_legal) begin
          p_addr_q  <= {dmem_addr[7:2], 2'b00};
          p_wdata_q <= wr_down;
        end
      end
      if (state_q == ST_CAPTURE) rdata_q <= rd_up;
      if (state_q == ST_RESP) begin
        err_q   <= 1'b0;
        rdata_q <= '0;
      end
    end
  end

  assign dmem_err   = err_q;
  assign dmem_rdata = rdata_q;
  assign p_addr     = p_addr_q;
  assign p_wdata    = p_wdata_q;
  assign dbg_state  = state_q;

endmodule
